// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states and
// byte-lane widths.
package lsu_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_STORE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extraction with sign/zero extension,
// sub-word store merge into a full word, and alignment check.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] merge_o,
  output logic              misaligned_o
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  assign byte_sel = word_i[{off_i, 3'b000} +: BYTE_W];
  assign half_sel = off_i[1] ? word_i[WORD_W-1:HALF_W] : word_i[HALF_W-1:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    load_o  = '0;
    merge_o = word_i;
    case (size_i)
      SZ_B: begin
        load_o = {{(WORD_W-BYTE_W){~unsigned_i & byte_sel[BYTE_W-1]}}, byte_sel};
        merge_o[{off_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
      end
      SZ_H: begin
        load_o = {{(WORD_W-HALF_W){~unsigned_i & half_sel[HALF_W-1]}}, half_sel};
        if (off_i[1]) merge_o[WORD_W-1:HALF_W] = wdata_i[HALF_W-1:0];
        else          merge_o[HALF_W-1:0]      = wdata_i[HALF_W-1:0];
      end
      SZ_W: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
      default: ;
    endcase
  end

  assign misaligned_o = ((size_i == SZ_H) && off_i[0]) ||
                        ((size_i == SZ_W) && (off_i != 2'b00));

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only, async-read data memory.
// Optional performance counters are enabled with `define LSU_PERF_CNT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       ld_cnt,
  output logic [31:0]       st_cnt
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("load_store_unit supports DATA_W == 32 only");
  end

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              idle;
  logic [1:0]        lane_off;
  logic [1:0]        lane_size;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merge_val;
  logic              misaligned;
  logic              req_bad;

  // Alignment is judged on the incoming request; extraction/merge on the latched one.
  assign idle      = (state_q == ST_IDLE);
  assign lane_off  = idle ? req_addr[1:0] : addr_q[1:0];
  assign lane_size = idle ? req_size      : size_q;

  lsu_lane_align u_lane_align (
    .word_i      (mem_rdata),
    .off_i       (lane_off),
    .size_i      (lane_size),
    .unsigned_i  (uns_q),
    .wdata_i     (wdata_q),
    .load_o      (load_val),
    .merge_o     (merge_val),
    .misaligned_o(misaligned)
  );

  assign req_bad = misaligned || (req_size == SZ_ILL);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          size_d      = req_size;
          we_d        = req_we;
          uns_d       = req_unsigned;
          wdata_d     = req_wdata;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (req_bad) begin
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end else if (!req_we) begin
            state_d = ST_LOAD;
          end else if (req_size == SZ_W) begin
            mem_wdata_d = req_wdata;
            state_d     = ST_STORE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        rsp_rdata_d = load_val;
        state_d     = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_wdata_d = merge_val;
        state_d     = ST_STORE;
      end
      ST_STORE: begin
        rsp_rdata_d = '0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= 2'b00;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = idle;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = (state_q == ST_STORE);
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = mem_wdata_q;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] ld_cnt_q, st_cnt_q;
  logic        rsp_done;

  assign rsp_done = rsp_valid && rsp_ready && !rsp_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else if (rsp_done) begin
      if (we_q) st_cnt_q <= st_cnt_q + 32'd1;
      else      ld_cnt_q <= ld_cnt_q + 32'd1;
    end
  end

  assign ld_cnt = ld_cnt_q;
  assign st_cnt = st_cnt_q;
`else
  assign ld_cnt = '0;
  assign st_cnt = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a word-addressed
// async-read memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ld_cnt, st_cnt;

  logic [31:0] mem [0:63];
  int checks = 0;
  int failures = 0;
  int we_pulses = 0;
  int exp_ld = 0;
  int exp_st = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ld_cnt(ld_cnt), .st_cnt(st_cnt)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      we_pulses++;
    end
  end

  // Issue one request from IDLE, measure accept-edge-to-rsp_valid latency,
  // capture the response and complete the handshake.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (ld_cnt !== 32'h0 || st_cnt !== 32'h0) begin failures++; $display("FAIL rst_counters got=%h/%h exp=0/0", ld_cnt, st_cnt); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    logic        we_t [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  sz_t [5]  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    logic        un_t [5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ad_t [5]  = '{32'h13, 32'h12, 32'h10, 32'h10, 32'h11};
    logic [31:0] ex_t [5]  = '{32'hFFFF_FF88, 32'h0000_8899, 32'hFFFF_AABB, 32'h8899_AABB, 32'h0000_00AA};
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          we_before;
    we_before = we_pulses;
    for (int i = 0; i < 5; i++) begin
      do_req(we_t[i], sz_t[i], un_t[i], ad_t[i], 32'h0, lat, rdata, err);
      exp_ld++;
      checks++; if (rdata !== ex_t[i]) begin failures++; $display("FAIL load%0d_rdata got=%h exp=%h", i, rdata, ex_t[i]); end
      checks++; if (lat !== 2 || err !== 1'b0) begin failures++; $display("FAIL load%0d_lat_err got=%0d/%b exp=2/0", i, lat, err); end
    end
    checks++; if (we_pulses !== we_before) begin failures++; $display("FAIL load_mem_we got=%0d exp=%0d", we_pulses, we_before); end
  endtask

  task automatic test_subword_store();
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          we_before;
    we_before = we_pulses;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_005A, lat, rdata, err);
    exp_st++;
    checks++; if (mem[4] !== 32'h8899_5ABB) begin failures++; $display("FAIL sb_mem got=%h exp=88995abb", mem[4]); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL sb_lat got=%0d exp=3", lat); end
    checks++; if (rdata !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL sb_rsp got=%h/%b exp=0/0", rdata, err); end
    checks++; if (we_pulses !== we_before + 1) begin failures++; $display("FAIL sb_we_pulses got=%0d exp=%0d", we_pulses, we_before + 1); end
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234, lat, rdata, err);
    exp_st++;
    checks++; if (mem[4] !== 32'h1234_5ABB) begin failures++; $display("FAIL sh_mem got=%h exp=12345abb", mem[4]); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL sh_lat got=%0d exp=3", lat); end
  endtask

  task automatic test_word_store();
    int          lat;
    logic [31:0] rdata;
    logic        err;
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, lat, rdata, err);
    exp_st++;
    checks++; if (mem[8] !== 32'hCAFE_F00D) begin failures++; $display("FAIL sw_mem got=%h exp=cafef00d", mem[8]); end
    checks++; if (lat !== 2 || err !== 1'b0) begin failures++; $display("FAIL sw_lat_err got=%0d/%b exp=2/0", lat, err); end
  endtask

  task automatic test_errors();
    logic        we_t [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  sz_t [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad_t [3] = '{32'h1, 32'h3, 32'h0};
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          we_before;
    we_before = we_pulses;
    for (int i = 0; i < 3; i++) begin
      do_req(we_t[i], sz_t[i], 1'b0, ad_t[i], 32'hDEAD_BEEF, lat, rdata, err);
      checks++; if (err !== 1'b1 || lat !== 1) begin failures++; $display("FAIL err%0d_flag_lat got=%b/%0d exp=1/1", i, err, lat); end
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL err%0d_rdata got=%h exp=0", i, rdata); end
    end
    checks++; if (we_pulses !== we_before) begin failures++; $display("FAIL err_mem_we got=%0d exp=%0d", we_pulses, we_before); end
`ifdef LSU_PERF_CNT_EN
    checks++; if (ld_cnt !== exp_ld || st_cnt !== exp_st) begin failures++; $display("FAIL err_counters got=%0d/%0d exp=%0d/%0d", ld_cnt, st_cnt, exp_ld, exp_st); end
`else
    checks++; if (ld_cnt !== 32'h0 || st_cnt !== 32'h0) begin failures++; $display("FAIL err_counters got=%0d/%0d exp=0/0", ld_cnt, st_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    int wait_cnt;
    int we_before;
    we_before = we_pulses;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h22; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_cnt = 0;
    while (!rsp_valid && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%b exp=1", rsp_valid); end
    // Competing word store held on the request port while the response stalls.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h48; req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_CAFE) begin failures++; $display("FAIL bp_hold%0d got=%b/%h exp=1/ffffcafe", i, rsp_valid, rsp_rdata); end
      checks++; if (req_ready !== 1'b0 || mem_addr !== 32'h20) begin failures++; $display("FAIL bp_ready_addr%0d got=%b/%h exp=0/00000020", i, req_ready, mem_addr); end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_ld++;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b/%b exp=0/1", rsp_valid, req_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (we_pulses !== we_before || mem[18] !== 32'h0) begin failures++; $display("FAIL bp_no_second_req got=%0d/%h exp=%0d/0", we_pulses, mem[18], we_before); end
  endtask

  task automatic test_reset_mid_rmw();
    int we_before;
    we_before = we_pulses;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h22; req_wdata = 32'h0000_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (mem_addr !== 32'h20 || req_ready !== 1'b0) begin failures++; $display("FAIL rmw_accept got=%h/%b exp=00000020/0", mem_addr, req_ready); end
    rst = 1'b0;
    #1;
    exp_ld = 0;
    exp_st = 0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rmw_rst_ctrl got=%b/%b/%b exp=1/0/0", req_ready, rsp_valid, mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL rmw_rst_mem got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem[8] !== 32'hCAFE_F00D || we_pulses !== we_before) begin failures++; $display("FAIL rmw_mem_unchanged got=%h/%0d exp=cafef00d/%0d", mem[8], we_pulses, we_before); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmw_no_rsp got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_counters();
    int          lat;
    logic [31:0] rdata;
    logic        err;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rdata, err);
    checks++; if (rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL cnt_lw got=%h exp=cafef00d", rdata); end
    do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, lat, rdata, err);
    checks++; if (rdata !== 32'h0000_00CA) begin failures++; $display("FAIL cnt_lbu got=%h exp=000000ca", rdata); end
    do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, lat, rdata, err);
    checks++; if (rdata !== 32'hFFFF_FFF0) begin failures++; $display("FAIL cnt_lb got=%h exp=fffffff0", rdata); end
    do_req(1'b1, 2'b00, 1'b0, 32'h40, 32'h0000_0077, lat, rdata, err);
    do_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, lat, rdata, err);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL cnt_err got=%b exp=1", err); end
    do_req(1'b1, 2'b10, 1'b0, 32'h44, 32'h1122_3344, lat, rdata, err);
    exp_ld += 3;
    exp_st += 2;
    checks++; if (mem[16] !== 32'h0000_0077 || mem[17] !== 32'h1122_3344) begin failures++; $display("FAIL cnt_mem got=%h/%h exp=00000077/11223344", mem[16], mem[17]); end
`ifdef LSU_PERF_CNT_EN
    checks++; if (ld_cnt !== 32'd3 || st_cnt !== 32'd2) begin failures++; $display("FAIL cnt_values got=%0d/%0d exp=3/2", ld_cnt, st_cnt); end
`else
    checks++; if (ld_cnt !== 32'd0 || st_cnt !== 32'd0) begin failures++; $display("FAIL cnt_values got=%0d/%0d exp=0/0", ld_cnt, st_cnt); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899_AABB;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    test_reset();
    test_loads();
    test_subword_store();
    test_word_store();
    test_errors();
    test_backpressure();
    test_reset_mid_rmw();
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute stage and the word-addressed data memory. The memory reads asynchronously and writes whole 32-bit words only.
- Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW: alignment check, load byte-lane extraction with sign/zero extension, and sub-word stores via a read-modify-write sequence.
- CPU side uses a valid/ready request and a valid/ready response.

Parameters:
- ADDR_W, 32, width of request and memory address.
- DATA_W, 32, data width. Fixed at 32; any other value is a compile-time error.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads (LBU/LHU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- rsp_valid  out  1  response valid
- rsp_ready  in  1  CPU accepts response
- rsp_rdata  out  DATA_W  extended load data (0 for stores)
- rsp_err  out  1  misaligned or illegal-size access
- mem_we  out  1  memory word write enable
- mem_addr  out  ADDR_W  word-aligned address, {a[31:2],2'b00}
- mem_wdata  out  DATA_W  full word to write
- mem_rdata  in  DATA_W  asynchronous memory read data
- ld_cnt  out  32  completed loads (see Optional Feature)
- st_cnt  out  32  completed stores (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=IDLE. req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0.
- FSM states: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE: req_ready=1 here only.
  - On req_valid, latch addr, size, we, unsigned and wdata.
  - Misaligned (half with a[0]=1, word with a[1:0]!=0) or size=11 -> RESP with rsp_err=1. No memory access.
  - Load -> LOAD. Word store -> STORE with mem_wdata=req_wdata. Byte/half store -> RMW_RD.
- LOAD: mem_addr driven.
  - Extract lane a[1:0] from mem_rdata.
  - Byte: sign/zero-extend bits [8*a+7:8*a]. Half: extend [16*a1+15:16*a1].
  - Register the result into rsp_rdata -> RESP.
- RMW_RD: capture mem_rdata. Replace the addressed lane(s) with req_wdata[7:0] or [15:0]; other bytes are unchanged. Result goes to mem_wdata -> STORE.
- STORE: mem_we=1 for exactly this one cycle -> RESP. rsp_rdata=0.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1, then -> IDLE.
  - A new request is not accepted in the same cycle as the response handshake.
- mem_we is 1 only in STORE. mem_addr is held at the latched address from accept until return to IDLE.
- Latency (accept edge to rsp_valid): load 2 cycles, word store 2 cycles, sub-word store 3 cycles, error 1 cycle.
- Reset mid-operation aborts immediately; no response is issued.
  - A partial write is impossible, because memory is written only in the single STORE cycle.
  - An RMW aborted in RMW_RD leaves memory unchanged.
- Error responses count as neither load nor store.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Defined:
  - ld_cnt increments on each RESP handshake of a non-error load; st_cnt does the same for stores.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Both reset to 0.
- Undefined: ld_cnt and st_cnt are tied to 0, and no counter flops are inferred.

Decomposition:
- Package lsu_pkg holds:
  - enum size_e {SZ_B, SZ_H, SZ_W, SZ_ILL};
  - enum lsu_state_e;
  - localparams for byte-lane widths.
- Sub-module lsu_lane_align: purely combinational.
  - Inputs: word, offset, size, unsigned, store data.
  - Outputs: extended load value, merged store word, misaligned flag.
  - Instantiated once; the FSM stays in load_store_unit.

Test Plan:
- mem[0x10]=0x8899AABB; LB at 0x13 -> rsp_rdata=0xFFFFFF88, 2 cycles, mem_we never asserted.
- Same word; LHU at 0x12 -> 0x00008899. LH at 0x10 -> 0xFFFFAABB.
- SB 0x5A at 0x11 -> one RMW_RD, then one mem_we pulse writing 0x8899 5A BB (0x88995ABB), rsp_valid after 3 cycles.
- SW 0xDEADBEEF at 0x1; then LH at 0x3 -> each gives rsp_err=1 after 1 cycle, no mem_we, counters unchanged.
- Hold rsp_ready=0 for 4 cycles after a load -> rsp_valid and rsp_rdata are stable, req_ready=0, no second request is accepted.
- Assert rst in RMW_RD of an SH -> outputs return to reset values at once, memory word is unchanged. With LSU_PERF_CNT_EN, 3 loads and 2 stores give ld_cnt=3, st_cnt=2.
